// File: rtl/ervp_register_file_access_ctrl.sv
// ervp_register_file_access_ctrl
//   Upstream access controller for a 1R1W register file. Write requests are
//   buffered in a WQ_DEPTH-entry circular queue and issued to the register
//   file write port one per cycle from the head. Reads are issued straight to
//   the synchronous read port. A read whose index matches any queued write is
//   stalled until that write has drained. A read response is held until the
//   consumer accepts it.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   wreq_*                 write request (valid/ready, index, lane permit, data)
//   rreq_*                 read request (valid/ready, index)
//   rrsp_*                 read response (valid/ready, data)
//   rf_index               shared index when the register file has one index
//   rf_windex/wenable/wpermit/wdata   register file write port
//   rf_rindex/renable/rdata_synch     register file read port
//   wq_count               number of queued writes
`timescale 1ns/1ps
module ervp_register_file_access_ctrl #(
    parameter int DEPTH            = 2,
    parameter int WIDTH            = 32,
    parameter int BW_INDEX         = 1,
    parameter int BW_SUBWORD       = 8,
    parameter int WQ_DEPTH         = 4,
    parameter int USE_SINGLE_INDEX = 0,
    localparam int BW_SELECT       = (WIDTH + BW_SUBWORD - 1) / BW_SUBWORD,
    localparam int BW_COUNT        = $clog2(WQ_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wreq_valid,
    output logic                 wreq_ready,
    input  logic [BW_INDEX-1:0]  wreq_index,
    input  logic [BW_SELECT-1:0] wreq_permit,
    input  logic [WIDTH-1:0]     wreq_data,
    input  logic                 rreq_valid,
    output logic                 rreq_ready,
    input  logic [BW_INDEX-1:0]  rreq_index,
    output logic                 rrsp_valid,
    input  logic                 rrsp_ready,
    output logic [WIDTH-1:0]     rrsp_data,
    output logic [BW_INDEX-1:0]  rf_index,
    output logic [BW_INDEX-1:0]  rf_windex,
    output logic                 rf_wenable,
    output logic [BW_SELECT-1:0] rf_wpermit,
    output logic [WIDTH-1:0]     rf_wdata,
    output logic [BW_INDEX-1:0]  rf_rindex,
    output logic                 rf_renable,
    input  logic [WIDTH-1:0]     rf_rdata_synch,
    output logic [BW_COUNT-1:0]  wq_count
);

    localparam int PTR_W = $clog2(WQ_DEPTH);

    // Elaboration-time sanity on parameters; the index itself is not range-checked.
    if (WQ_DEPTH < 2 || (WQ_DEPTH & (WQ_DEPTH - 1)) != 0) begin : g_bad_wq_depth
        $error("WQ_DEPTH must be a power of two and at least 2");
    end
    if (DEPTH < 1 || DEPTH > (1 << BW_INDEX)) begin : g_bad_depth
        $error("DEPTH must fit in BW_INDEX bits");
    end

    typedef struct packed {
        logic [BW_INDEX-1:0]  index;
        logic [BW_SELECT-1:0] permit;
        logic [WIDTH-1:0]     data;
    } wq_entry_t;

    wq_entry_t            wq_mem_q [WQ_DEPTH];
    wq_entry_t            wq_entry_d;
    wq_entry_t            head;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     offset;
    logic [BW_COUNT-1:0]  count_q, count_d;
    logic                 rrsp_valid_q, rrsp_valid_d;
    logic                 full, empty, hzd, slot_free;
    logic                 rd_fire, wr_push, wr_issue;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        full       = (count_q == BW_COUNT'(WQ_DEPTH));
        empty      = (count_q == '0);
        head       = wq_mem_q[rd_ptr_q];
        wq_entry_d = '{index: wreq_index, permit: wreq_permit, data: wreq_data};

        // Hazard: any occupied slot (distance from head below count) with a
        // matching index. The entry issuing this cycle still counts, so the
        // read lands no earlier than the cycle after the write commits.
        hzd    = 1'b0;
        offset = '0;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, offset} < count_q) && (wq_mem_q[i].index == rreq_index)) begin
                hzd = 1'b1;
            end
        end

        // With a shared index, reads win the slot unless the queue is full.
        slot_free  = (USE_SINGLE_INDEX != 0) ? !full : 1'b1;
        rreq_ready = !rst && !hzd && (!rrsp_valid_q || rrsp_ready) && slot_free;
        rd_fire    = rreq_valid && rreq_ready;
        wreq_ready = !rst && !full;
        wr_push    = wreq_valid && wreq_ready;
        wr_issue   = !rst && !empty && ((USE_SINGLE_INDEX == 0) || !rd_fire);

        wr_ptr_d = wr_push  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = wr_issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + BW_COUNT'(wr_push) - BW_COUNT'(wr_issue);

        // A new accept re-arms the response; otherwise it clears on handshake.
        if (rd_fire) begin
            rrsp_valid_d = 1'b1;
        end else if (rrsp_ready) begin
            rrsp_valid_d = 1'b0;
        end else begin
            rrsp_valid_d = rrsp_valid_q;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge value of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rrsp_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rrsp_valid_q <= rrsp_valid_d;
        end
    end

    // NOTE: queue storage has no reset; occupancy is tracked by the pointers
    // and count, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (wr_push) begin
            wq_mem_q[wr_ptr_q] <= wq_entry_d;
        end
    end

    // Register file write port: head entry, masked off when nothing issues.
    assign rf_wenable = 1'b1;
    assign rf_windex  = head.index;
    assign rf_wpermit = wr_issue ? head.permit : '0;
    assign rf_wdata   = head.data;

    // Read port; renable stays low while a response is stalled, which keeps
    // rf_rdata_synch (and so rrsp_data) stable.
    assign rf_rindex  = rreq_index;
    assign rf_renable = rd_fire;
    assign rf_index   = rd_fire ? rreq_index : head.index;

    assign rrsp_valid = rrsp_valid_q;
    assign rrsp_data  = rf_rdata_synch;
    assign wq_count   = count_q;

endmodule

// File: tb/tb_ervp_register_file_access_ctrl.sv
// Testbench for ervp_register_file_access_ctrl. Two instances: "d" with
// separate read/write indices (WQ_DEPTH=4) and "s" with a shared index
// (WQ_DEPTH=2). Each has a behavioural 1R1W register file. A reference memory
// updated at request acceptance feeds a scoreboard of expected read data.
`timescale 1ns/1ps
module tb_ervp_register_file_access_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // d instance signals
    logic        d_wreq_valid, d_wreq_ready, d_rreq_valid, d_rreq_ready;
    logic [2:0]  d_wreq_index, d_rreq_index, d_rf_index, d_rf_windex, d_rf_rindex;
    logic [3:0]  d_wreq_permit, d_rf_wpermit;
    logic [31:0] d_wreq_data, d_rrsp_data, d_rf_wdata, d_rf_rdata;
    logic        d_rrsp_valid, d_rrsp_ready, d_rf_wenable, d_rf_renable;
    logic [2:0]  d_wq_count;

    // s instance signals
    logic        s_wreq_valid, s_wreq_ready, s_rreq_valid, s_rreq_ready;
    logic [2:0]  s_wreq_index, s_rreq_index, s_rf_index, s_rf_windex, s_rf_rindex;
    logic [3:0]  s_wreq_permit, s_rf_wpermit;
    logic [31:0] s_wreq_data, s_rrsp_data, s_rf_wdata, s_rf_rdata;
    logic        s_rrsp_valid, s_rrsp_ready, s_rf_wenable, s_rf_renable;
    logic [1:0]  s_wq_count;

    ervp_register_file_access_ctrl #(
        .DEPTH(8), .WIDTH(32), .BW_INDEX(3), .BW_SUBWORD(8), .WQ_DEPTH(4), .USE_SINGLE_INDEX(0)
    ) dut_d (
        .clk(clk), .rst(rst),
        .wreq_valid(d_wreq_valid), .wreq_ready(d_wreq_ready), .wreq_index(d_wreq_index),
        .wreq_permit(d_wreq_permit), .wreq_data(d_wreq_data),
        .rreq_valid(d_rreq_valid), .rreq_ready(d_rreq_ready), .rreq_index(d_rreq_index),
        .rrsp_valid(d_rrsp_valid), .rrsp_ready(d_rrsp_ready), .rrsp_data(d_rrsp_data),
        .rf_index(d_rf_index), .rf_windex(d_rf_windex), .rf_wenable(d_rf_wenable),
        .rf_wpermit(d_rf_wpermit), .rf_wdata(d_rf_wdata), .rf_rindex(d_rf_rindex),
        .rf_renable(d_rf_renable), .rf_rdata_synch(d_rf_rdata), .wq_count(d_wq_count)
    );

    ervp_register_file_access_ctrl #(
        .DEPTH(8), .WIDTH(32), .BW_INDEX(3), .BW_SUBWORD(8), .WQ_DEPTH(2), .USE_SINGLE_INDEX(1)
    ) dut_s (
        .clk(clk), .rst(rst),
        .wreq_valid(s_wreq_valid), .wreq_ready(s_wreq_ready), .wreq_index(s_wreq_index),
        .wreq_permit(s_wreq_permit), .wreq_data(s_wreq_data),
        .rreq_valid(s_rreq_valid), .rreq_ready(s_rreq_ready), .rreq_index(s_rreq_index),
        .rrsp_valid(s_rrsp_valid), .rrsp_ready(s_rrsp_ready), .rrsp_data(s_rrsp_data),
        .rf_index(s_rf_index), .rf_windex(s_rf_windex), .rf_wenable(s_rf_wenable),
        .rf_wpermit(s_rf_wpermit), .rf_wdata(s_rf_wdata), .rf_rindex(s_rf_rindex),
        .rf_renable(s_rf_renable), .rf_rdata_synch(s_rf_rdata), .wq_count(s_wq_count)
    );

    // Behavioural register files (lane-masked write, registered read).
    logic [31:0] rfm_d [8] = '{default: 32'h0};
    logic [31:0] rfm_s [8] = '{default: 32'h0};

    always @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (d_rf_wpermit[l]) rfm_d[d_rf_windex][l*8 +: 8] <= d_rf_wdata[l*8 +: 8];
        end
        if (d_rf_renable) d_rf_rdata <= rfm_d[d_rf_rindex];
    end

    // Shared-index register file: one address for both ports.
    always @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (s_rf_wpermit[l]) rfm_s[s_rf_index][l*8 +: 8] <= s_rf_wdata[l*8 +: 8];
        end
        if (s_rf_renable) s_rf_rdata <= rfm_s[s_rf_index];
    end

    // Reference state and scoreboards.
    logic [31:0] ref_d [8];
    logic [31:0] ref_s [8];
    logic [31:0] exp_d [$];
    logic [31:0] exp_s [$];
    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] permit);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++) if (permit[l]) r[l*8 +: 8] = data[l*8 +: 8];
        return r;
    endfunction

    // Runs once per cycle at the falling edge: retire responses, then record
    // read accepts (old data), then apply write accepts to the reference.
    task automatic monitor();
        logic [31:0] e;
        if (rst) begin
            exp_d.delete();
            exp_s.delete();
            ref_d = rfm_d;
            ref_s = rfm_s;
        end else begin
            if (d_rrsp_valid && d_rrsp_ready) begin
                checks++;
                if (exp_d.size() == 0) begin
                    errors++; $display("FAIL d_rsp_unexpected: got %h, none expected", d_rrsp_data);
                end else begin
                    e = exp_d.pop_front();
                    if (d_rrsp_data !== e) begin
                        errors++; $display("FAIL d_rsp_data: got %h want %h", d_rrsp_data, e);
                    end
                end
            end
            if (d_rreq_valid && d_rreq_ready) exp_d.push_back(ref_d[d_rreq_index]);
            if (d_wreq_valid && d_wreq_ready)
                ref_d[d_wreq_index] = merge(ref_d[d_wreq_index], d_wreq_data, d_wreq_permit);

            if (s_rrsp_valid && s_rrsp_ready) begin
                checks++;
                if (exp_s.size() == 0) begin
                    errors++; $display("FAIL s_rsp_unexpected: got %h, none expected", s_rrsp_data);
                end else begin
                    e = exp_s.pop_front();
                    if (s_rrsp_data !== e) begin
                        errors++; $display("FAIL s_rsp_data: got %h want %h", s_rrsp_data, e);
                    end
                end
            end
            if (s_rreq_valid && s_rreq_ready) exp_s.push_back(ref_s[s_rreq_index]);
            if (s_wreq_valid && s_wreq_ready)
                ref_s[s_wreq_index] = merge(ref_s[s_wreq_index], s_wreq_data, s_wreq_permit);
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        monitor();
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        d_wreq_valid = 1'b1; d_rreq_valid = 1'b1;
        s_wreq_valid = 1'b1; s_rreq_valid = 1'b1;
        at_neg();
        checks++; if (d_wreq_ready !== 1'b0) begin errors++; $display("FAIL rst_d_wreq_ready: got %b want 0", d_wreq_ready); end
        checks++; if (d_rreq_ready !== 1'b0) begin errors++; $display("FAIL rst_d_rreq_ready: got %b want 0", d_rreq_ready); end
        checks++; if (s_wreq_ready !== 1'b0) begin errors++; $display("FAIL rst_s_wreq_ready: got %b want 0", s_wreq_ready); end
        checks++; if (s_rreq_ready !== 1'b0) begin errors++; $display("FAIL rst_s_rreq_ready: got %b want 0", s_rreq_ready); end
        checks++; if (d_rf_renable !== 1'b0) begin errors++; $display("FAIL rst_d_renable: got %b want 0", d_rf_renable); end
        to_next();
        at_neg();
        to_next();
        rst = 1'b0;
        d_wreq_valid = 1'b0; d_rreq_valid = 1'b0;
        s_wreq_valid = 1'b0; s_rreq_valid = 1'b0;
        at_neg();
        checks++; if (d_wq_count !== 3'd0) begin errors++; $display("FAIL rst_d_count: got %0d want 0", d_wq_count); end
        checks++; if (s_wq_count !== 2'd0) begin errors++; $display("FAIL rst_s_count: got %0d want 0", s_wq_count); end
        checks++; if (d_rrsp_valid !== 1'b0) begin errors++; $display("FAIL rst_d_rrsp_valid: got %b want 0", d_rrsp_valid); end
        checks++; if (s_rrsp_valid !== 1'b0) begin errors++; $display("FAIL rst_s_rrsp_valid: got %b want 0", s_rrsp_valid); end
        checks++; if (d_wreq_ready !== 1'b1) begin errors++; $display("FAIL post_rst_wreq_ready: got %b want 1", d_wreq_ready); end
        checks++; if (d_rf_wenable !== 1'b1) begin errors++; $display("FAIL rf_wenable: got %b want 1", d_rf_wenable); end
        checks++; if (d_rf_wpermit !== 4'h0) begin errors++; $display("FAIL idle_wpermit: got %h want 0", d_rf_wpermit); end
        to_next();
    endtask

    task automatic test_write_read();
        d_wreq_valid = 1'b1; d_wreq_index = 3'd3; d_wreq_data = 32'hDEADBEEF; d_wreq_permit = 4'hF;
        at_neg();
        checks++; if (d_wreq_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", d_wreq_ready); end
        to_next();
        d_wreq_valid = 1'b0;
        at_neg();
        checks++; if (d_wq_count !== 3'd1) begin errors++; $display("FAIL wr_count: got %0d want 1", d_wq_count); end
        checks++; if (d_rf_wpermit !== 4'hF) begin errors++; $display("FAIL wr_issue_permit: got %h want f", d_rf_wpermit); end
        checks++; if (d_rf_windex !== 3'd3) begin errors++; $display("FAIL wr_issue_index: got %0d want 3", d_rf_windex); end
        checks++; if (d_rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_issue_data: got %h want deadbeef", d_rf_wdata); end
        to_next();
        d_rreq_valid = 1'b1; d_rreq_index = 3'd3;
        at_neg();
        checks++; if (d_rreq_ready !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b want 1", d_rreq_ready); end
        checks++; if (d_rf_renable !== 1'b1) begin errors++; $display("FAIL rd_renable: got %b want 1", d_rf_renable); end
        checks++; if (d_rrsp_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp_early: got %b want 0", d_rrsp_valid); end
        checks++; if (d_wq_count !== 3'd0) begin errors++; $display("FAIL wr_drained: got %0d want 0", d_wq_count); end
        to_next();
        d_rreq_valid = 1'b0;
        at_neg();
        checks++; if (d_rrsp_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp_valid: got %b want 1", d_rrsp_valid); end
        checks++; if (d_rrsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rsp_data: got %h want deadbeef", d_rrsp_data); end
        to_next();
        at_neg();
        checks++; if (d_rrsp_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp_clear: got %b want 0", d_rrsp_valid); end
        to_next();
    endtask

    task automatic test_lane_permit();
        d_wreq_valid = 1'b1; d_wreq_index = 3'd1; d_wreq_data = 32'h11223344; d_wreq_permit = 4'hF;
        at_neg();
        to_next();
        d_wreq_data = 32'hAABBCCDD; d_wreq_permit = 4'b0101;
        at_neg();
        checks++; if (d_wq_count !== 3'd1) begin errors++; $display("FAIL lane_count1: got %0d want 1", d_wq_count); end
        to_next();
        d_wreq_valid = 1'b0;
        at_neg();
        checks++; if (d_wq_count !== 3'd1) begin errors++; $display("FAIL lane_pushpop_count: got %0d want 1", d_wq_count); end
        checks++; if (d_rf_wpermit !== 4'b0101) begin errors++; $display("FAIL lane_permit: got %b want 0101", d_rf_wpermit); end
        to_next();
        d_rreq_valid = 1'b1; d_rreq_index = 3'd1;
        at_neg();
        checks++; if (d_rreq_ready !== 1'b1) begin errors++; $display("FAIL lane_rd_ready: got %b want 1", d_rreq_ready); end
        to_next();
        d_rreq_valid = 1'b0;
        at_neg();
        checks++; if (d_rrsp_data !== 32'h11BB33DD) begin errors++; $display("FAIL lane_data: got %h want 11bb33dd", d_rrsp_data); end
        to_next();
    endtask

    task automatic test_hazard();
        d_wreq_valid = 1'b1; d_wreq_index = 3'd5; d_wreq_data = 32'h55; d_wreq_permit = 4'hF;
        at_neg();
        to_next();
        d_wreq_valid = 1'b0;
        d_rreq_valid = 1'b1; d_rreq_index = 3'd5;
        at_neg();
        checks++; if (d_rreq_ready !== 1'b0) begin errors++; $display("FAIL hzd_stall: got %b want 0", d_rreq_ready); end
        checks++; if (d_rf_renable !== 1'b0) begin errors++; $display("FAIL hzd_renable: got %b want 0", d_rf_renable); end
        to_next();
        at_neg();
        checks++; if (d_rreq_ready !== 1'b1) begin errors++; $display("FAIL hzd_release: got %b want 1", d_rreq_ready); end
        to_next();
        d_rreq_valid = 1'b0;
        at_neg();
        checks++; if (d_rrsp_data !== 32'h55) begin errors++; $display("FAIL hzd_data: got %h want 00000055", d_rrsp_data); end
        to_next();
    endtask

    task automatic test_backpressure();
        d_rreq_valid = 1'b1; d_rreq_index = 3'd3;
        at_neg();
        to_next();
        d_rrsp_ready = 1'b0; d_rreq_index = 3'd5;
        for (int k = 0; k < 3; k++) begin
            at_neg();
            checks++; if (d_rrsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", k, d_rrsp_valid); end
            checks++; if (d_rrsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_data[%0d]: got %h want deadbeef", k, d_rrsp_data); end
            checks++; if (d_rreq_ready !== 1'b0) begin errors++; $display("FAIL bp_rreq_ready[%0d]: got %b want 0", k, d_rreq_ready); end
            to_next();
        end
        d_rrsp_ready = 1'b1;
        at_neg();
        checks++; if (d_rreq_ready !== 1'b1) begin errors++; $display("FAIL bp_same_cycle_accept: got %b want 1", d_rreq_ready); end
        to_next();
        d_rreq_valid = 1'b0;
        at_neg();
        checks++; if (d_rrsp_data !== 32'h55) begin errors++; $display("FAIL bp_next_data: got %h want 00000055", d_rrsp_data); end
        to_next();
    endtask

    task automatic test_back_to_back();
        logic [2:0] idx [4];
        idx = '{3'd3, 3'd5, 3'd1, 3'd3};
        for (int k = 0; k < 4; k++) begin
            d_rreq_valid = 1'b1; d_rreq_index = idx[k];
            // A write accepted alongside the first read is ordered after it.
            d_wreq_valid = (k == 0); d_wreq_index = 3'd3; d_wreq_data = 32'h33333333; d_wreq_permit = 4'hF;
            at_neg();
            checks++; if (d_rreq_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, d_rreq_ready); end
            if (k == 1) begin
                checks++; if (d_rf_wpermit !== 4'hF) begin errors++; $display("FAIL b2b_dual_issue: got %h want f", d_rf_wpermit); end
                checks++; if (d_rrsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_old_data: got %h want deadbeef", d_rrsp_data); end
            end
            if (k > 0) begin
                checks++; if (d_rrsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, d_rrsp_valid); end
            end
            to_next();
        end
        d_rreq_valid = 1'b0; d_wreq_valid = 1'b0;
        at_neg();
        checks++; if (d_rrsp_data !== 32'h33333333) begin errors++; $display("FAIL b2b_new_data: got %h want 33333333", d_rrsp_data); end
        to_next();
        at_neg();
        to_next();
    endtask

    task automatic test_single_index();
        s_rreq_valid = 1'b1; s_rreq_index = 3'd7;
        s_wreq_valid = 1'b1; s_wreq_index = 3'd1; s_wreq_data = 32'hA1A1A1A1; s_wreq_permit = 4'hF;
        at_neg();
        checks++; if (s_rreq_ready !== 1'b1) begin errors++; $display("FAIL si_c0_rreq_ready: got %b want 1", s_rreq_ready); end
        checks++; if (s_wreq_ready !== 1'b1) begin errors++; $display("FAIL si_c0_wreq_ready: got %b want 1", s_wreq_ready); end
        checks++; if (s_rf_index !== 3'd7) begin errors++; $display("FAIL si_c0_index: got %0d want 7", s_rf_index); end
        checks++; if (s_rf_wpermit !== 4'h0) begin errors++; $display("FAIL si_c0_wpermit: got %h want 0", s_rf_wpermit); end
        to_next();
        s_wreq_index = 3'd2; s_wreq_data = 32'hB2B2B2B2;
        at_neg();
        checks++; if (s_wq_count !== 2'd1) begin errors++; $display("FAIL si_c1_count: got %0d want 1", s_wq_count); end
        checks++; if (s_wreq_ready !== 1'b1) begin errors++; $display("FAIL si_c1_wreq_ready: got %b want 1", s_wreq_ready); end
        checks++; if (s_rf_wpermit !== 4'h0) begin errors++; $display("FAIL si_c1_wpermit: got %h want 0", s_rf_wpermit); end
        to_next();
        s_wreq_index = 3'd3; s_wreq_data = 32'hC3C3C3C3;
        at_neg();
        checks++; if (s_wq_count !== 2'd2) begin errors++; $display("FAIL si_c2_count: got %0d want 2", s_wq_count); end
        checks++; if (s_wreq_ready !== 1'b0) begin errors++; $display("FAIL si_c2_wreq_ready: got %b want 0", s_wreq_ready); end
        checks++; if (s_rreq_ready !== 1'b0) begin errors++; $display("FAIL si_c2_rreq_ready: got %b want 0", s_rreq_ready); end
        checks++; if (s_rf_wpermit !== 4'hF) begin errors++; $display("FAIL si_c2_wpermit: got %h want f", s_rf_wpermit); end
        checks++; if (s_rf_index !== 3'd1) begin errors++; $display("FAIL si_c2_index: got %0d want 1", s_rf_index); end
        checks++; if (s_rf_wdata !== 32'hA1A1A1A1) begin errors++; $display("FAIL si_c2_wdata: got %h want a1a1a1a1", s_rf_wdata); end
        to_next();
        at_neg();
        checks++; if (s_wq_count !== 2'd1) begin errors++; $display("FAIL si_c3_count: got %0d want 1", s_wq_count); end
        checks++; if (s_rreq_ready !== 1'b1) begin errors++; $display("FAIL si_c3_rreq_ready: got %b want 1", s_rreq_ready); end
        checks++; if (s_rf_wpermit !== 4'h0) begin errors++; $display("FAIL si_c3_wpermit: got %h want 0", s_rf_wpermit); end
        to_next();
        s_wreq_valid = 1'b0;
        at_neg();
        checks++; if (s_rreq_ready !== 1'b0) begin errors++; $display("FAIL si_c4_rreq_ready: got %b want 0", s_rreq_ready); end
        checks++; if (s_rf_index !== 3'd2) begin errors++; $display("FAIL si_c4_index: got %0d want 2", s_rf_index); end
        to_next();
        s_rreq_valid = 1'b0;
        at_neg();
        checks++; if (s_rf_wpermit !== 4'hF) begin errors++; $display("FAIL si_c5_wpermit: got %h want f", s_rf_wpermit); end
        to_next();
        at_neg();
        checks++; if (s_wq_count !== 2'd0) begin errors++; $display("FAIL si_drain: got %0d want 0", s_wq_count); end
        to_next();
    endtask

    task automatic test_reset_midop();
        s_rreq_valid = 1'b1; s_rreq_index = 3'd7;
        s_wreq_valid = 1'b1; s_wreq_index = 3'd2; s_wreq_data = 32'h99999999; s_wreq_permit = 4'hF;
        at_neg();
        to_next();
        s_wreq_index = 3'd3; s_wreq_data = 32'h88888888;
        at_neg();
        checks++; if (s_wq_count !== 2'd1) begin errors++; $display("FAIL mid_count: got %0d want 1", s_wq_count); end
        to_next();
        rst = 1'b1;
        at_neg();
        checks++; if (s_rf_wpermit !== 4'h0) begin errors++; $display("FAIL mid_rst_wpermit: got %h want 0", s_rf_wpermit); end
        checks++; if (s_rreq_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_rreq_ready: got %b want 0", s_rreq_ready); end
        to_next();
        rst = 1'b0; s_wreq_valid = 1'b0; s_rreq_valid = 1'b0;
        at_neg();
        checks++; if (s_wq_count !== 2'd0) begin errors++; $display("FAIL mid_count_clr: got %0d want 0", s_wq_count); end
        checks++; if (s_rrsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_drop: got %b want 0", s_rrsp_valid); end
        checks++; if (rfm_s[2] !== 32'hB2B2B2B2) begin errors++; $display("FAIL mid_rf2: got %h want b2b2b2b2", rfm_s[2]); end
        checks++; if (rfm_s[3] !== 32'hC3C3C3C3) begin errors++; $display("FAIL mid_rf3: got %h want c3c3c3c3", rfm_s[3]); end
        to_next();
        s_rreq_valid = 1'b1; s_rreq_index = 3'd2;
        at_neg();
        checks++; if (s_rreq_ready !== 1'b1) begin errors++; $display("FAIL mid_rd_ready: got %b want 1", s_rreq_ready); end
        to_next();
        s_rreq_valid = 1'b0;
        at_neg();
        checks++; if (s_rrsp_data !== 32'hB2B2B2B2) begin errors++; $display("FAIL mid_rd_data: got %h want b2b2b2b2", s_rrsp_data); end
        to_next();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        d_wreq_valid = 1'b0; d_wreq_index = '0; d_wreq_permit = '0; d_wreq_data = '0;
        d_rreq_valid = 1'b0; d_rreq_index = '0; d_rrsp_ready = 1'b1;
        s_wreq_valid = 1'b0; s_wreq_index = '0; s_wreq_permit = '0; s_wreq_data = '0;
        s_rreq_valid = 1'b0; s_rreq_index = '0; s_rrsp_ready = 1'b1;

        test_reset();
        test_write_read();
        test_lane_permit();
        test_hazard();
        test_backpressure();
        test_back_to_back();
        test_single_index();
        test_reset_midop();

        checks++; if (exp_d.size() != 0) begin errors++; $display("FAIL d_scoreboard_left: got %0d want 0", exp_d.size()); end
        checks++; if (exp_s.size() != 0) begin errors++; $display("FAIL s_scoreboard_left: got %0d want 0", exp_s.size()); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
